line_buffer_window: RTL and testbench

Parametrised single-line pixel buffer for the convolution front end. It stores one image line, written one pixel per accepted write. On each accepted read it presents a TAPS-pixel horizontal window as a registered output, then advances by one pixel. Over the previous generation it adds: generic width, depth and tap count; occupancy tracking; write back-pressure; read gating; wrap for any LINE_LEN; sticky error flags; and an end-of-line pulse. Several instances are chained by the window/kernel controller, one per image row.

---
 rtl/line_buffer_window.sv | 115 +++++++++++
 tb/tb_line_buffer_window.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_window.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_window
// Brief    : Single image-line pixel buffer emitting a TAPS-wide registered
//            horizontal window per accepted read, with occupancy and flags.
// Revision : 1.0
// ============================================================================
module line_buffer_window #(
  parameter  int DATA_W   = 8,
  parameter  int LINE_LEN = 512,
  parameter  int TAPS     = 3,
  localparam int PTR_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1,
  localparam int CNT_W    = $clog2(LINE_LEN + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_data_valid,
  output logic                   o_ready,
  input  logic                   i_rd_data,
  output logic [TAPS*DATA_W-1:0] o_data,
  output logic                   o_data_valid,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_line_done,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam logic [PTR_W:0]   c_LEN_W = (PTR_W+1)'(LINE_LEN);
  localparam logic [PTR_W-1:0] c_LAST  = PTR_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] c_FULL  = CNT_W'(LINE_LEN);
  localparam logic [CNT_W-1:0] c_TAPS  = CNT_W'(TAPS);

  logic [DATA_W-1:0]      r_mem [LINE_LEN];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [TAPS*DATA_W-1:0] r_data;
  logic                   r_data_valid;
  logic                   r_line_done;
  logic                   r_overflow;
  logic                   r_underflow;

  logic                   w_ready;
  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic [PTR_W-1:0]       w_wr_ptr_nxt;
  logic [PTR_W-1:0]       w_rd_ptr_nxt;
  logic [TAPS*DATA_W-1:0] w_window;

  assign w_ready      = (r_count != c_FULL);
  assign w_wr_acc     = i_data_valid & w_ready;
  assign w_rd_acc     = i_rd_data & (r_count >= c_TAPS);
  assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;

  // Tap t reads rd_ptr+t modulo LINE_LEN; tap0 lands in the MSBs.
  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_addr;
    assign w_sum  = {1'b0, r_rd_ptr} + (PTR_W+1)'(t);
    assign w_addr = PTR_W'((w_sum >= c_LEN_W) ? (w_sum - c_LEN_W) : w_sum);
    assign w_window[(TAPS-1-t)*DATA_W +: DATA_W] = r_mem[w_addr];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_line_done  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_acc) begin
        r_data   <= w_window;
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      r_data_valid <= w_rd_acc;
      r_line_done  <= w_wr_acc & (r_wr_ptr == c_LAST);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_data_valid & ~w_ready) begin
        r_overflow <= 1'b1;
      end
      if (i_rd_data & (r_count < c_TAPS)) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_ready      = w_ready;
  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_count      = r_count;
  assign o_line_done  = r_line_done;
  assign o_overflow   = r_overflow;
  assign o_underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_buffer_window
// Brief    : Vector table plus random stream against a pixel-queue model and
//            a window scoreboard; LINE_LEN=5, TAPS=3, DATA_W=8.
// Revision : 1.0
// ============================================================================
module tb_line_buffer_window;

  localparam int DW = 8;
  localparam int LL = 5;
  localparam int TP = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    i_data;
  logic             i_data_valid;
  logic             o_ready;
  logic             i_rd_data;
  logic [TP*DW-1:0] o_data;
  logic             o_data_valid;
  logic [2:0]       o_count;
  logic             o_line_done;
  logic             o_overflow;
  logic             o_underflow;

  always #5 clk = ~clk;

  line_buffer_window #(.DATA_W(DW), .LINE_LEN(LL), .TAPS(TP)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_ready      (o_ready),
    .i_rd_data    (i_rd_data),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_count      (o_count),
    .o_line_done  (o_line_done),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow)
  );

  typedef struct {
    bit          rst;
    bit          wr;
    logic [7:0]  d;
    bit          rd;
    int          cnt;
    bit          rdy;
    bit          done;
    bit          ovf;
    bit          udf;
  } vec_t;

  vec_t             tab[$];
  logic [7:0]       mq[$];
  logic [TP*DW-1:0] sb[$];
  logic [TP*DW-1:0] m_last;
  int               m_wptr;
  bit               m_ovf, m_udf, m_done, m_valid;
  int               n_vec = 0;
  int               n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %0h expected %0h", nm, n_vec, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input bit hand);
    int               pre;
    bit               rdacc, wracc;
    logic [TP*DW-1:0] w;
    @(negedge clk);
    rst          = v.rst;
    i_data_valid = v.wr;
    i_data       = v.d;
    i_rd_data    = v.rd;
    pre          = mq.size();
    if (v.rst) begin
      mq.delete();
      sb.delete();
      m_wptr = 0; m_last = '0; m_ovf = 0; m_udf = 0; m_done = 0; m_valid = 0;
    end else begin
      rdacc   = v.rd && (pre >= TP);
      wracc   = v.wr && (pre != LL);
      m_valid = rdacc;
      m_done  = wracc && (m_wptr == LL - 1);
      if (v.wr && pre == LL) m_ovf = 1;
      if (v.rd && pre < TP)  m_udf = 1;
      if (rdacc) begin
        w = {mq[0], mq[1], mq[2]};
        sb.push_back(w);
        m_last = w;
        void'(mq.pop_front());
      end
      if (wracc) begin
        mq.push_back(v.d);
        m_wptr = (m_wptr + 1) % LL;
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    chk("count", 32'(o_count), hand ? 32'(v.cnt) : 32'(mq.size()));
    chk("ready", 32'(o_ready), hand ? 32'(v.rdy) : 32'(mq.size() != LL));
    chk("line_done", 32'(o_line_done), hand ? 32'(v.done) : 32'(m_done));
    chk("overflow", 32'(o_overflow), hand ? 32'(v.ovf) : 32'(m_ovf));
    chk("underflow", 32'(o_underflow), hand ? 32'(v.udf) : 32'(m_udf));
    chk("data_valid", 32'(o_data_valid), 32'(m_valid));
    chk("data_hold", 32'(o_data), 32'(m_last));
    if (o_data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL window: got %06h with no window expected", o_data);
      end else begin
        chk("window", 32'(o_data), 32'(sb.pop_front()));
      end
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; i_data_valid = 1'b0; i_data = '0; i_rd_data = 1'b0;
    //              rst wr d      rd cnt rdy dn ov ud
    tab.push_back('{1, 0, 8'h00, 0, 0, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h10, 0, 1, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h11, 0, 2, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h12, 0, 3, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h13, 0, 4, 1, 0, 0, 0});
    tab.push_back('{0, 0, 8'h00, 1, 3, 1, 0, 0, 0}); // 101112
    tab.push_back('{0, 0, 8'h00, 1, 2, 1, 0, 0, 0}); // 111213
    tab.push_back('{0, 0, 8'h00, 1, 2, 1, 0, 0, 1});
    tab.push_back('{1, 0, 8'h00, 0, 0, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h01, 0, 1, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h02, 0, 2, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h03, 0, 3, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h04, 0, 4, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h05, 0, 5, 0, 1, 0, 0});
    tab.push_back('{0, 1, 8'h06, 0, 5, 0, 0, 1, 0});
    tab.push_back('{0, 0, 8'h00, 1, 4, 1, 0, 1, 0}); // 010203
    tab.push_back('{0, 0, 8'h00, 1, 3, 1, 0, 1, 0}); // 020304
    tab.push_back('{0, 0, 8'h00, 1, 2, 1, 0, 1, 0}); // 030405
    tab.push_back('{0, 1, 8'h06, 0, 3, 1, 0, 1, 0});
    tab.push_back('{0, 1, 8'h07, 0, 4, 1, 0, 1, 0});
    tab.push_back('{0, 0, 8'h00, 1, 3, 1, 0, 1, 0}); // 040506
    tab.push_back('{0, 0, 8'h00, 1, 2, 1, 0, 1, 0}); // 050607
    tab.push_back('{0, 1, 8'h08, 0, 3, 1, 0, 1, 0});
    tab.push_back('{0, 1, 8'h09, 0, 4, 1, 0, 1, 0});
    tab.push_back('{0, 1, 8'h0A, 0, 5, 0, 1, 1, 0});
    tab.push_back('{0, 1, 8'h0B, 1, 4, 1, 0, 1, 0}); // full: write dropped, 060708
    tab.push_back('{0, 0, 8'h00, 1, 3, 1, 0, 1, 0}); // 070809
    tab.push_back('{0, 1, 8'h0C, 1, 3, 1, 0, 1, 0}); // both accepted, 08090A
    tab.push_back('{1, 1, 8'h0D, 1, 0, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h21, 0, 1, 1, 0, 0, 0});
    tab.push_back('{0, 1, 8'h22, 0, 2, 1, 0, 0, 0});
    tab.push_back('{0, 0, 8'h00, 1, 2, 1, 0, 0, 1});
    tab.push_back('{0, 1, 8'h23, 0, 3, 1, 0, 0, 1});
    tab.push_back('{0, 1, 8'h24, 1, 3, 1, 0, 0, 1}); // 212223
    tab.push_back('{0, 0, 8'h00, 1, 2, 1, 0, 0, 1}); // 222324
    foreach (tab[i]) step(tab[i], 1'b1);

    // Random traffic with occasional resets, checked against the model only.
    for (int i = 0; i < 400; i++) begin
      v.rst = ($urandom_range(0, 60) == 0);
      v.wr  = ($urandom_range(0, 2) != 0);
      v.d   = 8'($urandom);
      v.rd  = ($urandom_range(0, 2) != 0);
      v.cnt = 0; v.rdy = 0; v.done = 0; v.ovf = 0; v.udf = 0;
      step(v, 1'b0);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
